// File: rtl/jt51_pg_pkg.sv
// Shared constants and helpers for the multi-slot JT51 phase generator.
// Holds the base-step ceiling, DT1 code fields, the octave shifter and the slot width.
package jt51_pg_pkg;

    localparam int MAX_BASE_DEF = 82976;

    // DT1 code: bit 2 selects subtract, bits [1:0] == 0 means no detune
    localparam int DT1_SUB_BIT = 2;
    localparam int DT1_MAG_HI  = 1;
    localparam int DT1_MAG_LO  = 0;

    function automatic int slot_w(input int slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

    function automatic logic [17:0] oct_shift(input logic [11:0] phinc,
                                              input logic [3:0]  octave);
        logic [17:0] wide;
        wide = {phinc, 6'b0};
        if (octave > 4'd8) return '0;
        return wide >> (4'd8 - octave);
    endfunction

endpackage

// File: rtl/jt51_pg_acc.sv
// Per-slot phase store and accumulate stage (IV to V).
// Read, update and write back one addressed slot per enabled cycle.
module jt51_pg_acc
    import jt51_pg_pkg::*;
#(
    parameter int SLOTS = 32,
    parameter int PH_W  = 20,
    parameter int OUT_W = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cen,
    input  logic [slot_w(SLOTS)-1:0]    slot,
    input  logic [PH_W-1:0]             step,
    input  logic                        freeze,
    input  logic                        pg_rst,
    input  logic [PH_W-1:0]             rst_phase,
    output logic [OUT_W-1:0]            ph,
    output logic [slot_w(SLOTS)-1:0]    ph_slot
);

    logic [PH_W-1:0] phase [SLOTS];
    logic [PH_W-1:0] old_ph;
    logic [PH_W-1:0] new_ph;

    // Key-on reset beats freeze, freeze beats accumulation
    always_comb begin
        old_ph = phase[slot];
        new_ph = old_ph + step;
        if (freeze) new_ph = old_ph;
        if (pg_rst) new_ph = rst_phase;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) phase[i] <= '0;
            ph      <= '0;
            ph_slot <= '0;
        end else if (cen) begin
            phase[slot] <= new_ph;
            ph          <= new_ph[PH_W-1 -: OUT_W];
            ph_slot     <= slot;
        end
    end

endmodule

// File: rtl/jt51_pg_mslot.sv
// Multi-slot JT51 phase generator: base step, DT1, multiplier and fixed-mode
// pipeline feeding an addressed per-slot phase accumulator.
module jt51_pg_mslot
    import jt51_pg_pkg::*;
#(
    parameter int SLOTS    = 32,
    parameter int PH_W     = 20,
    parameter int OUT_W    = 10,
    parameter int MAX_BASE = MAX_BASE_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cen,
    input  logic                        zero,
    input  logic [11:0]                 phinc_I,
    input  logic [3:0]                  octave_I,
    input  logic [4:0]                  dt1_off_I,
    input  logic [2:0]                  dt1_I,
    input  logic [3:0]                  mul_I,
    input  logic                        fixed_I,
    input  logic [PH_W-1:0]             fixed_step_I,
    input  logic                        freeze_I,
    input  logic                        pg_rst_I,
    input  logic [PH_W-1:0]             rst_phase_I,
    output logic [OUT_W-1:0]            ph_V,
    output logic [slot_w(SLOTS)-1:0]    slot_V
);

    localparam int SW = slot_w(SLOTS);

    typedef struct packed {
        logic            fixed;
        logic [PH_W-1:0] step;
    } fix_t;

    typedef struct packed {
        logic            freeze;
        logic            pg_rst;
        logic [PH_W-1:0] rst_phase;
        logic [SW-1:0]   slot;
    } side_t;

    logic [SW-1:0]   slot_cnt;
    logic [SW-1:0]   slot_i;
    logic [17:0]     raw_i;
    logic [17:0]     base_i;
    fix_t            fix_i;
    side_t           side_i;

    logic [17:0]     base_ii;
    logic [4:0]      dt1_off_ii;
    logic [2:0]      dt1_ii;
    logic [3:0]      mul_ii;
    fix_t            fix_ii;
    side_t           side_ii;
    logic [19:0]     dt_next;

    logic [19:0]     dt_iii;
    logic [3:0]      mul_iii;
    fix_t            fix_iii;
    side_t           side_iii;
    logic [PH_W-1:0] s_iii;
    logic [PH_W-1:0] step_next;

    logic [PH_W-1:0] step_iv;
    side_t           side_iv;

    // slot_cnt holds the slot expected next; zero forces the current input to slot 0
    always_comb begin
        slot_i           = zero ? '0 : slot_cnt;
        raw_i            = oct_shift(phinc_I, octave_I);
        base_i           = (raw_i > 18'(MAX_BASE)) ? 18'(MAX_BASE) : raw_i;
        fix_i.fixed      = fixed_I;
        fix_i.step       = fixed_step_I;
        side_i.freeze    = freeze_I;
        side_i.pg_rst    = pg_rst_I;
        side_i.rst_phase = rst_phase_I;
        side_i.slot      = slot_i;
    end

    always_comb begin
        dt_next = {2'b0, base_ii};
        if (dt1_ii[DT1_MAG_HI:DT1_MAG_LO] != 2'b00) begin
            if (dt1_ii[DT1_SUB_BIT]) dt_next = {2'b0, base_ii} - {15'b0, dt1_off_ii};
            else                     dt_next = {2'b0, base_ii} + {15'b0, dt1_off_ii};
        end
    end

    // Wider accumulators keep the 20-bit step aligned to the phase MSBs
    always_comb begin
        s_iii = PH_W'(dt_iii);
        s_iii = s_iii << (PH_W - 20);
        if (mul_iii == 4'd0) step_next = s_iii >> 1;
        else                 step_next = s_iii * PH_W'(mul_iii);
        if (fix_iii.fixed)   step_next = fix_iii.step;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt   <= '0;
            base_ii    <= '0;
            dt1_off_ii <= '0;
            dt1_ii     <= '0;
            mul_ii     <= '0;
            fix_ii     <= '0;
            side_ii    <= '0;
            dt_iii     <= '0;
            mul_iii    <= '0;
            fix_iii    <= '0;
            side_iii   <= '0;
            step_iv    <= '0;
            side_iv    <= '0;
        end else if (cen) begin
            slot_cnt   <= slot_i + SW'(1);
            base_ii    <= base_i;
            dt1_off_ii <= dt1_off_I;
            dt1_ii     <= dt1_I;
            mul_ii     <= mul_I;
            fix_ii     <= fix_i;
            side_ii    <= side_i;
            dt_iii     <= dt_next;
            mul_iii    <= mul_ii;
            fix_iii    <= fix_ii;
            side_iii   <= side_ii;
            step_iv    <= step_next;
            side_iv    <= side_iii;
        end
    end

    jt51_pg_acc #(
        .SLOTS (SLOTS),
        .PH_W  (PH_W),
        .OUT_W (OUT_W)
    ) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .slot      (side_iv.slot),
        .step      (step_iv),
        .freeze    (side_iv.freeze),
        .pg_rst    (side_iv.pg_rst),
        .rst_phase (side_iv.rst_phase),
        .ph        (ph_V),
        .ph_slot   (slot_V)
    );

endmodule

// File: tb/tb_jt51_pg_mslot.sv
// Bench for jt51_pg_mslot: random slot traffic against an arithmetic phase model,
// plus directed frames for base, DT1, clamp, fixed mode, key-on reset and resync.
module tb_jt51_pg_mslot;

    localparam int SLOTS = 32;
    localparam int PH_W  = 20;
    localparam int OUT_W = 10;
    localparam int SW    = 5;
    localparam int W     = SW + OUT_W;
    localparam longint MAXB = 82976;
    localparam longint MOD  = 64'd1 << PH_W;

    logic             clk;
    logic             rst_n;
    logic             cen;
    logic             zero;
    logic [11:0]      phinc_I;
    logic [3:0]       octave_I;
    logic [4:0]       dt1_off_I;
    logic [2:0]       dt1_I;
    logic [3:0]       mul_I;
    logic             fixed_I;
    logic [PH_W-1:0]  fixed_step_I;
    logic             freeze_I;
    logic             pg_rst_I;
    logic [PH_W-1:0]  rst_phase_I;
    logic [OUT_W-1:0] ph_V;
    logic [SW-1:0]    slot_V;

    jt51_pg_mslot #(.SLOTS(SLOTS), .PH_W(PH_W), .OUT_W(OUT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cen          (cen),
        .zero         (zero),
        .phinc_I      (phinc_I),
        .octave_I     (octave_I),
        .dt1_off_I    (dt1_off_I),
        .dt1_I        (dt1_I),
        .mul_I        (mul_I),
        .fixed_I      (fixed_I),
        .fixed_step_I (fixed_step_I),
        .freeze_I     (freeze_I),
        .pg_rst_I     (pg_rst_I),
        .rst_phase_I  (rst_phase_I),
        .ph_V         (ph_V),
        .slot_V       (slot_V)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit zero;
        int phinc;
        int octave;
        int dt1_off;
        int dt1;
        int mul;
        bit fixed;
        int fixed_step;
        bit freeze;
        bit pg_rst;
        int rst_phase;
    } stim_t;

    longint       ref_ph [SLOTS];
    int           m_next;
    logic [W-1:0] exp_q [$];
    int           checks;
    int           passes;

    // reference model: frequency rules as plain integer arithmetic
    function automatic longint ref_step(input stim_t s);
        longint base;
        longint dt;
        longint st;
        if (s.octave > 8) base = 0;
        else              base = (s.phinc * 64) / (64'd1 << (8 - s.octave));
        if (base > MAXB) base = MAXB;
        if (s.dt1 % 4 == 0)  dt = base;
        else if (s.dt1 >= 4) dt = (base - s.dt1_off + (64'd1 << 20)) % (64'd1 << 20);
        else                 dt = base + s.dt1_off;
        dt = dt * (64'd1 << (PH_W - 20));
        if (s.mul == 0) st = dt / 2;
        else            st = (dt * s.mul) % MOD;
        if (s.fixed) st = s.fixed_step;
        return st;
    endfunction

    function automatic stim_t plain(input int phinc, input int octave, input int mul);
        stim_t s;
        s = '{default: 0};
        s.phinc  = phinc;
        s.octave = octave;
        s.mul    = mul;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.zero       = 1'b0;
        s.phinc      = $urandom_range(0, 4095);
        s.octave     = $urandom_range(0, 15);
        s.dt1_off    = $urandom_range(0, 31);
        s.dt1        = $urandom_range(0, 7);
        s.mul        = $urandom_range(0, 15);
        s.fixed      = ($urandom_range(0, 7) == 0);
        s.fixed_step = $urandom_range(0, (1 << PH_W) - 1);
        s.freeze     = ($urandom_range(0, 7) == 0);
        s.pg_rst     = ($urandom_range(0, 9) == 0);
        s.rst_phase  = $urandom_range(0, (1 << PH_W) - 1);
        return s;
    endfunction

    // scoreboard
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < SLOTS; i++) ref_ph[i] = 0;
        m_next = 0;
        exp_q.delete();
    endtask

    // driver: one slot per enabled cycle; result emerges on the 4th edge
    task automatic drive(input stim_t s);
        int           slot;
        longint       nph;
        logic [W-1:0] e;
        slot   = s.zero ? 0 : m_next;
        m_next = (slot + 1) % SLOTS;
        if (s.pg_rst)      nph = s.rst_phase;
        else if (s.freeze) nph = ref_ph[slot];
        else               nph = (ref_ph[slot] + ref_step(s)) % MOD;
        ref_ph[slot] = nph;
        exp_q.push_back({SW'(slot), OUT_W'(nph >> (PH_W - OUT_W))});
        zero         = s.zero;
        phinc_I      = 12'(s.phinc);
        octave_I     = 4'(s.octave);
        dt1_off_I    = 5'(s.dt1_off);
        dt1_I        = 3'(s.dt1);
        mul_I        = 4'(s.mul);
        fixed_I      = s.fixed;
        fixed_step_I = PH_W'(s.fixed_step);
        freeze_I     = s.freeze;
        pg_rst_I     = s.pg_rst;
        rst_phase_I  = PH_W'(s.rst_phase);
        cen          = 1'b1;
        @(posedge clk);
        #1;
        if (exp_q.size() == 4) begin
            e = exp_q.pop_front();
            check("pipe", {slot_V, ph_V}, e);
        end
    endtask

    task automatic idle(input int n);
        cen = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one frame: target slot gets ts, others random; literal check on the target's output
    task automatic frame(input int tgt, input stim_t ts, input int lit, input string tag);
        for (int s = 0; s < SLOTS; s++) begin
            stim_t st;
            st      = (s == tgt) ? ts : rand_stim();
            st.zero = (s == 0);
            drive(st);
            if (s == tgt + 3) check(tag, {slot_V, ph_V}, {SW'(tgt), OUT_W'(lit)});
        end
    endtask

    initial begin
        stim_t t;
        checks = 0;
        passes = 0;
        model_reset();
        rst_n = 1'b0; cen = 1'b0; zero = 1'b0;
        phinc_I = '0; octave_I = '0; dt1_off_I = '0; dt1_I = '0; mul_I = '0;
        fixed_I = 1'b0; fixed_step_I = '0; freeze_I = 1'b0; pg_rst_I = 1'b0; rst_phase_I = '0;
        #12;
        check("reset_out", {slot_V, ph_V}, '0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // base step and accumulation on slot 3
        t = plain(1299, 4, 1);
        frame(3, t, 5, "base_f1");
        frame(3, t, 10, "base_f2");
        frame(3, t, 15, "base_f3");

        // half multiplier, then DT1 add / subtract
        t = plain(0, 0, 1); t.pg_rst = 1'b1; t.rst_phase = 0;
        frame(3, t, 0, "dt_clr");
        t = plain(1299, 4, 0);
        frame(3, t, 2, "half_mul");
        t = plain(1299, 4, 1); t.dt1 = 1; t.dt1_off = 22;
        frame(3, t, 7, "dt1_add");
        t.dt1 = 5;
        frame(3, t, 12, "dt1_sub");

        // clamp, truncation, octave above 8
        t = plain(0, 0, 1); t.pg_rst = 1'b1; t.rst_phase = 0;
        frame(9, t, 0, "clamp_clr");
        t = plain(4095, 8, 15);
        frame(9, t, 191, "clamp");
        t = plain(4095, 9, 5);
        frame(9, t, 191, "oct9");

        // fixed mode wrap and freeze
        t = plain(0, 0, 1); t.pg_rst = 1'b1; t.rst_phase = 0;
        frame(5, t, 0, "fix_clr");
        t = plain(1299, 4, 1); t.fixed = 1'b1; t.fixed_step = 524288;
        frame(5, t, 512, "fix_1");
        frame(5, t, 0, "fix_2");
        frame(5, t, 512, "fix_3");
        t.freeze = 1'b1;
        frame(5, t, 512, "freeze");

        // key-on reset wins over fixed and freeze
        t = plain(1299, 4, 1); t.pg_rst = 1'b1; t.rst_phase = 1000;
        t.fixed = 1'b1; t.fixed_step = 12345; t.freeze = 1'b1;
        frame(7, t, 0, "keyon");
        t = plain(1299, 4, 1);
        frame(7, t, 6, "keyon_next");

        // random traffic with stalls
        for (int f = 0; f < 4; f++) begin
            for (int s = 0; s < SLOTS; s++) begin
                t      = rand_stim();
                t.zero = (s == 0);
                drive(t);
                if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
            end
        end

        // asynchronous reset mid-frame, between enabled edges
        for (int s = 0; s < 10; s++) begin
            t      = rand_stim();
            t.zero = (s == 0);
            drive(t);
        end
        cen = 1'b0;
        #3 rst_n = 1'b0;
        #1 check("midreset", {slot_V, ph_V}, '0);
        #3 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        for (int s = 0; s < SLOTS; s++) begin
            t        = plain(4095, 7, 3);
            t.freeze = 1'b1;
            t.zero   = (s == 0);
            drive(t);
        end

        // zero pulse at slot 17 realigns the counter
        for (int s = 0; s < 17; s++) begin
            t      = rand_stim();
            t.zero = (s == 0);
            drive(t);
        end
        t      = rand_stim();
        t.zero = 1'b1;
        drive(t);
        for (int s = 0; s < 3; s++) drive(rand_stim());
        check("resync", W'(slot_V), W'(0));
        for (int s = 0; s < 8; s++) drive(rand_stim());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/jt51_pg_mslot.md
Name: jt51_pg_mslot

Overview:
- Parametrised successor of the JT51 phase generator.
- Time-multiplexed accumulator for SLOTS operator slots, with configurable phase width.
- Adds per-slot fixed-frequency mode, phase freeze and programmable reset phase.
- Per-slot phase is stored in an addressed register array rather than a circulating shift register; an internal slot counter is resynchronised by `zero`.
- Sits between the phinc ROM / DT1 lookup and the operator.

Parameters:
- SLOTS, 32, operator slots per frame. Power of two, 4..64.
- PH_W, 20, phase accumulator width. Must be ≥ 20.
- OUT_W, 10, output phase MSBs. Must be ≤ PH_W.
- MAX_BASE, 82976, clamp ceiling for the 18-bit base step.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cen  in  1  clock enable; one slot per enabled cycle
- zero  in  1  marks the stage-I input as slot 0
- phinc_I  in  12  phinc ROM value
- octave_I  in  4  octave
- dt1_off_I  in  5  DT1 magnitude
- dt1_I  in  3  DT1 code; bit 2 = subtract, bits[1:0]==0 = no detune
- mul_I  in  4  multiplier; 0 means ×½
- fixed_I  in  1  fixed-frequency mode
- fixed_step_I  in  PH_W  step used in fixed mode
- freeze_I  in  1  hold phase (no advance)
- pg_rst_I  in  1  key-on phase reset
- rst_phase_I  in  PH_W  phase loaded on pg_rst_I
- ph_V  out  OUT_W  phase MSBs, stage V
- slot_V  out  $clog2(SLOTS)  slot index aligned with ph_V

Behaviour:
- All state advances only when cen=1. rst_n low clears all pipeline registers, the slot counter, ph_V, slot_V and every phase array entry to 0, immediately.
- Slot counter:
  - zero=1 sets the stage-I slot to 0; otherwise the slot increments.
  - The counter wraps from SLOTS-1 to 0.
  - If zero arrives mid-frame, the counter re-aligns immediately; no phase entry is cleared.
- Stage I→II, base:
  - octave ≤ 8: base = ({phinc,6'b0} >> (8-octave)), kept as 18 bits.
  - octave > 8: base = 0.
  - base > MAX_BASE → clamp to MAX_BASE.
- Stage II→III, DT1:
  - dt1[1:0]==0 → base unchanged.
  - Otherwise base ± dt1_off, computed in 20 bits, no saturation.
- Stage III→IV, multiply:
  - s = dt1 result << (PH_W-20).
  - mul=0 → step = s>>1; else step = s·mul, truncated to PH_W bits.
  - fixed_I=1 overrides the step with fixed_step_I.
- Stage IV→V, accumulate:
  - The phase array is read at the stage-IV slot address and written back in the same enabled cycle.
  - Write-back value, in priority order: pg_rst → rst_phase_I; freeze → old phase; else old phase + step modulo 2^PH_W.
- Output: ph_V = written value[PH_W-1:PH_W-OUT_W]; slot_V = its slot.
- Latency: inputs presented at stage I appear on ph_V 4 cen cycles later.
- Control sideband: fixed_I, fixed_step_I, freeze_I, pg_rst_I and rst_phase_I are sampled at stage I and pipelined alongside the data.
- Same-slot hazard: a slot is revisited after SLOTS ≥ 4 cycles, so no read-after-write hazard exists; no bypass is needed.
- Simultaneous pg_rst and fixed/freeze: pg_rst wins.
- cen=0: every register holds, including the array.

Decomposition:
- Package jt51_pg_pkg holds:
  - MAX_BASE default;
  - the octave shift function;
  - DT1 code field positions;
  - the slot index width function.
- One sub-module, jt51_pg_acc: phase array plus accumulate/priority logic (stage IV→V). The remainder stays in jt51_pg_mslot.

Test Plan:
1. Base step and accumulation:
   - Stimulus: slot 3 with phinc=1299, octave=4, dt1=0, mul=1, PH_W=20.
   - Response: step=5196. Slot-3 phase after 3 frames = 15588, ph_V = 15.
2. Half multiplier, DT1 and ordering:
   - Stimulus: same slot with mul=0, then with mul=1 plus dt1=3'b001, dt1_off=22, then dt1=3'b101.
   - Response: steps 2598, 5218 and 5174. Other slots are unaffected.
3. Clamp and truncation:
   - Stimulus: phinc=4095, octave=8, mul=15.
   - Response: base clamped to 82976; step = 1244640 mod 2^20 = 196064.
   - Also: octave=9 gives step 0.
4. Fixed mode and wrap:
   - Stimulus: fixed_I=1, fixed_step_I=524288.
   - Response: phase sequence 524288, 0, 524288; ph_V toggles 512/0.
   - Also: freeze_I=1 holds the value.
5. Key-on reset priority:
   - Stimulus: pg_rst_I with rst_phase_I=1000, together with fixed_I=1.
   - Response: the written phase is exactly 1000, and accumulation resumes from 1000 next frame.
6. Reset and resync:
   - Stimulus: assert rst_n low mid-frame between cen pulses.
   - Response: ph_V = 0 and slot_V = 0 immediately, with all slots at 0 after release.
   - Also: a zero pulse at slot 17 realigns slot_V to 0 four cycles later.
